// File: rtl/convolutor_seq_ctrl_if.sv
// +--------------------------------------------------------------------+
// | convolutor_seq_ctrl_if: start/size control, X/Y read, Z write bus  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface convolutor_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_X = 5,
    parameter int ADDR_Y = 5,
    parameter int ADDR_Z = 6,
    parameter int ACC_W  = 2*DATA_W + ADDR_X
);
    logic              start_i;
    logic [ADDR_X:0]   size_x_i;
    logic [ADDR_Y:0]   size_y_i;
    logic [ADDR_X-1:0] mem_x_addr_o;
    logic              mem_x_rd_o;
    logic [DATA_W-1:0] mem_x_data_i;
    logic [ADDR_Y-1:0] mem_y_addr_o;
    logic              mem_y_rd_o;
    logic [DATA_W-1:0] mem_y_data_i;
    logic [ADDR_Z-1:0] z_addr_o;
    logic [ACC_W-1:0]  z_data_o;
    logic              z_write_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  start_i, size_x_i, size_y_i, mem_x_data_i, mem_y_data_i,
        output mem_x_addr_o, mem_x_rd_o, mem_y_addr_o, mem_y_rd_o,
               z_addr_o, z_data_o, z_write_o, busy_o, done_o
    );

    modport master (
        output start_i, size_x_i, size_y_i, mem_x_data_i, mem_y_data_i,
        input  mem_x_addr_o, mem_x_rd_o, mem_y_addr_o, mem_y_rd_o,
               z_addr_o, z_data_o, z_write_o, busy_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/convolutor_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | convolutor_seq_ctrl: sequencer for 1-D convolution Z = X * Y       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module convolutor_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_X = 5,
    parameter int ADDR_Y = 5,
    parameter int ADDR_Z = 6,
    parameter int RD_LAT = 1,
    parameter int ACC_W  = 2*DATA_W + ADDR_X
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    convolutor_seq_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int              CW       = ADDR_Z + 1;
    localparam logic [ADDR_X:0] NX_MAX   = {1'b1, {ADDR_X{1'b0}}};
    localparam logic [ADDR_Y:0] NY_MAX   = {1'b1, {ADDR_Y{1'b0}}};
    localparam logic [1:0]      DRN_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_X:0]   nx_q, nx_d;
    logic [ADDR_Y:0]   ny_q, ny_d;
    logic [ADDR_Z-1:0] i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [1:0]        drn_q, drn_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_X-1:0] xaddr_q, xaddr_d;
    logic [ADDR_Y-1:0] yaddr_q, yaddr_d;
    logic [ADDR_Z-1:0] zaddr_q, zaddr_d;
    logic [ACC_W-1:0]  zdata_q, zdata_d;

    logic [CW-1:0]     w_nx, w_ny, w_i, w_i_nxt, w_jhi, w_jlo_nxt;
    logic [ADDR_X-1:0] w_xaddr;
    logic [ADDR_Y-1:0] w_yaddr;
    logic [DATA_W-1:0] w_x, w_y;
    logic [ACC_W-1:0]  w_prod;
    logic              w_issue, w_last_j, w_last_i;

    assign w_nx      = CW'(nx_q);
    assign w_ny      = CW'(ny_q);
    assign w_i       = CW'(i_q);
    assign w_i_nxt   = w_i + CW'(1);
    assign w_jhi     = (w_i < w_nx - CW'(1)) ? w_i : w_nx - CW'(1);
    // Lowest X index that still overlaps Y for the following output word
    assign w_jlo_nxt = (w_i_nxt + CW'(1) > w_ny) ? w_i_nxt + CW'(1) - w_ny : '0;
    assign w_last_j  = (j_q == w_jhi);
    assign w_last_i  = (w_i == w_nx + w_ny - CW'(2));
    assign w_issue   = (state_q == S_ISSUE);
    assign w_xaddr   = ADDR_X'(j_q);
    assign w_yaddr   = ADDR_Y'(w_i - j_q);
    assign w_x       = bus.mem_x_data_i;
    assign w_y       = bus.mem_y_data_i;
    assign w_prod    = ACC_W'(w_x) * ACC_W'(w_y);

    generate
        if (RD_LAT == 1) begin : g_vld_one
            assign vld_d = w_issue;
        end else begin : g_vld_pipe
            assign vld_d = {vld_q[RD_LAT-2:0], w_issue};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_SETUP;
            S_SETUP: state_d = (nx_q == '0 || ny_q == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_last_j) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == DRN_LAST) state_d = S_WRITE;
            S_WRITE: state_d = w_last_i ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        nx_d    = nx_q;
        ny_d    = ny_q;
        i_d     = i_q;
        j_d     = j_q;
        drn_d   = drn_q;
        acc_d   = acc_q;
        xaddr_d = xaddr_q;
        yaddr_d = yaddr_q;
        zaddr_d = zaddr_q;
        zdata_d = zdata_q;
        if (vld_q[RD_LAT-1]) acc_d = acc_q + w_prod;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    nx_d = (bus.size_x_i > NX_MAX) ? NX_MAX : bus.size_x_i;
                    ny_d = (bus.size_y_i > NY_MAX) ? NY_MAX : bus.size_y_i;
                end
            end
            S_SETUP: begin
                i_d   = '0;
                j_d   = '0;
                acc_d = '0;
            end
            S_ISSUE: begin
                xaddr_d = w_xaddr;
                yaddr_d = w_yaddr;
                j_d     = j_q + CW'(1);
                drn_d   = '0;
            end
            S_DRAIN: drn_d = drn_q + 2'd1;
            S_WRITE: begin
                zaddr_d = i_q;
                zdata_d = acc_q;
                acc_d   = '0;
                i_d     = i_q + ADDR_Z'(1);
                j_d     = w_jlo_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_q    <= '0;
            ny_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            drn_q   <= '0;
            vld_q   <= '0;
            acc_q   <= '0;
            xaddr_q <= '0;
            yaddr_q <= '0;
            zaddr_q <= '0;
            zdata_q <= '0;
        end else begin
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            i_q     <= i_d;
            j_q     <= j_d;
            drn_q   <= drn_d;
            vld_q   <= vld_d;
            acc_q   <= acc_d;
            xaddr_q <= xaddr_d;
            yaddr_q <= yaddr_d;
            zaddr_q <= zaddr_d;
            zdata_q <= zdata_d;
        end
    end

    always_comb begin
        bus.mem_x_rd_o   = w_issue;
        bus.mem_y_rd_o   = w_issue;
        bus.mem_x_addr_o = w_issue ? w_xaddr : xaddr_q;
        bus.mem_y_addr_o = w_issue ? w_yaddr : yaddr_q;
        bus.z_write_o    = (state_q == S_WRITE);
        bus.z_addr_o     = (state_q == S_WRITE) ? i_q : zaddr_q;
        bus.z_data_o     = (state_q == S_WRITE) ? acc_q : zdata_q;
        bus.busy_o       = (state_q == S_SETUP) || (state_q == S_ISSUE) ||
                           (state_q == S_DRAIN) || (state_q == S_WRITE);
        bus.done_o       = (state_q == S_DONE);
    end
endmodule

`default_nettype wire

// File: tb/tb_convolutor_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_convolutor_seq_ctrl: scoreboard bench, RD_LAT=1 and RD_LAT=3    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_convolutor_seq_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_X = 5;
    localparam int ADDR_Y = 5;
    localparam int ADDR_Z = 6;
    localparam int ACC_W  = 2*DATA_W + ADDR_X;

    typedef struct {
        int sx;
        int sy;
        int fill;
        int busy1;
        int busy3;
        int writes;
        int p1;
        int p2;
    } vec_t;

    typedef struct {
        int     addr;
        longint data;
    } zexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start;
    logic [ADDR_X:0]   size_x;
    logic [ADDR_Y:0]   size_y;
    logic [DATA_W-1:0] mem_x [32];
    logic [DATA_W-1:0] mem_y [32];

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    zexp_t  sbq [2][$];
    int     writes   [2];
    int     reads_x  [2];
    int     reads_y  [2];
    int     busy_cnt [2];
    int     done_cyc [2];
    int     done_cnt [2];
    int     since_rd [2];
    longint cap      [2][64];
    logic [1:0] any_w;
    logic [1:0] busy_w;
    logic [1:0] rd_w;
    int     exp_a [4] = '{4, 13, 22, 15};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        convolutor_seq_ctrl_if #(.DATA_W(DATA_W), .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y),
                                 .ADDR_Z(ADDR_Z), .ACC_W(ACC_W)) bus ();
        logic [DATA_W-1:0] px [LAT];
        logic [DATA_W-1:0] py [LAT];

        assign bus.start_i      = start;
        assign bus.size_x_i     = size_x;
        assign bus.size_y_i     = size_y;
        assign bus.mem_x_data_i = px[LAT-1];
        assign bus.mem_y_data_i = py[LAT-1];
        assign any_w[g]  = |{bus.mem_x_addr_o, bus.mem_x_rd_o, bus.mem_y_addr_o, bus.mem_y_rd_o,
                             bus.z_addr_o, bus.z_data_o, bus.z_write_o, bus.busy_o, bus.done_o};
        assign busy_w[g] = bus.busy_o;
        assign rd_w[g]   = bus.mem_x_rd_o;

        convolutor_seq_ctrl #(.DATA_W(DATA_W), .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y),
                              .ADDR_Z(ADDR_Z), .RD_LAT(LAT), .ACC_W(ACC_W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        // Memory model: unread cycles return noise so misaligned accumulation shows up
        always @(posedge clk) begin
            px[0] <= bus.mem_x_rd_o ? mem_x[bus.mem_x_addr_o] : DATA_W'($urandom);
            py[0] <= bus.mem_y_rd_o ? mem_y[bus.mem_y_addr_o] : DATA_W'($urandom);
            for (int k = 1; k < LAT; k++) begin
                px[k] <= px[k-1];
                py[k] <= py[k-1];
            end
        end

        always @(negedge clk) begin
            zexp_t e;
            if (bus.busy_o) busy_cnt[g]++;
            if (bus.done_o) begin
                done_cnt[g]++;
                if (done_cyc[g] < 0) done_cyc[g] = cyc;
            end
            if (bus.mem_y_rd_o) reads_y[g]++;
            if (bus.mem_x_rd_o) begin
                reads_x[g]++;
                since_rd[g] = 0;
            end else begin
                since_rd[g]++;
            end
            if (bus.z_write_o) begin
                writes[g]++;
                check($sformatf("drain_gap[%0d]", g), since_rd[g], LAT + 1);
                if (sbq[g].size() == 0) begin
                    check($sformatf("extra_write[%0d]", g), writes[g], 0);
                end else begin
                    e = sbq[g].pop_front();
                    check($sformatf("z_addr[%0d]", g), bus.z_addr_o, e.addr);
                    check($sformatf("z_data[%0d] i=%0d", g, e.addr), bus.z_data_o, e.data);
                    cap[g][e.addr] = bus.z_data_o;
                end
            end
        end
    end

    task automatic prep(input vec_t v);
        int nx, ny, nz;
        nx = (v.sx > 32) ? 32 : v.sx;
        ny = (v.sy > 32) ? 32 : v.sy;
        nz = (nx == 0 || ny == 0) ? 0 : nx + ny - 1;
        for (int k = 0; k < 32; k++) begin
            case (v.fill)
                0:       begin mem_x[k] = 8'(k + 1); mem_y[k] = 8'(k + 4); end
                1:       begin mem_x[k] = 8'd255;    mem_y[k] = 8'd255;    end
                default: begin mem_x[k] = 8'($urandom); mem_y[k] = 8'($urandom); end
            endcase
        end
        for (int g = 0; g < 2; g++) begin
            sbq[g].delete();
            writes[g] = 0; reads_x[g] = 0; reads_y[g] = 0; busy_cnt[g] = 0;
            done_cyc[g] = -1; done_cnt[g] = 0; since_rd[g] = 0;
            for (int a = 0; a < 64; a++) cap[g][a] = -1;
        end
        for (int i = 0; i < nz; i++) begin
            zexp_t  e;
            longint s;
            s = 0;
            for (int j = 0; j < nx; j++)
                if (i - j >= 0 && i - j < ny) s += longint'(mem_x[j]) * longint'(mem_y[i-j]);
            e.addr = i;
            e.data = s;
            sbq[0].push_back(e);
            sbq[1].push_back(e);
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        size_x = 6'(v.sx);
        size_y = 6'(v.sy);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        size_x = 6'($urandom);
        size_y = 6'($urandom);
        cyc    = 1;
    endtask

    task automatic run_case(input vec_t v);
        int nx, ny, eb;
        prep(v);
        launch(v);
        for (int k = 0; k < 5000 && (done_cyc[0] < 0 || done_cyc[1] < 0); k++) begin
            start = (v.p1 != 0 && cyc == v.p1) || (v.p2 != 0 && cyc == v.p2);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nx = (v.sx > 32) ? 32 : v.sx;
        ny = (v.sy > 32) ? 32 : v.sy;
        for (int g = 0; g < 2; g++) begin
            eb = (g == 0) ? v.busy1 : v.busy3;
            check($sformatf("busy_cycles[%0d] %0dx%0d", g, v.sx, v.sy), busy_cnt[g], eb);
            check($sformatf("done_cycle[%0d]", g), done_cyc[g], eb + 1);
            check($sformatf("done_pulses[%0d]", g), done_cnt[g], 1);
            check($sformatf("write_count[%0d]", g), writes[g], v.writes);
            check($sformatf("x_reads[%0d]", g), reads_x[g], nx * ny);
            check($sformatf("y_reads[%0d]", g), reads_y[g], nx * ny);
            check($sformatf("sb_left[%0d]", g), sbq[g].size(), 0);
            check($sformatf("idle_after[%0d]", g), busy_w[g], 0);
        end
    endtask

    task automatic check_caps_a();
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 4; a++)
                check($sformatf("z_small[%0d][%0d]", g, a), cap[g][a], exp_a[a]);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t v;
        vecs[0] = '{3,  2,  0, 15,   23,   4,  5, 16};
        vecs[1] = '{0,  4,  0, 1,    1,    0,  0, 0};
        vecs[2] = '{32, 32, 1, 1151, 1277, 63, 0, 0};
        vecs[3] = '{40, 3,  2, 165,  233,  34, 0, 0};
        vecs[4] = '{1,  1,  2, 4,    6,    1,  0, 0};
        vecs[5] = '{5,  0,  2, 1,    1,    0,  0, 0};
        vecs[6] = '{2,  32, 2, 131,  197,  33, 0, 0};

        start  = 1'b0;
        size_x = '0;
        size_y = '0;
        for (int g = 0; g < 2; g++) done_cyc[g] = -1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("reset_outputs[%0d]", g), any_w[g], 0);
        #2 rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            run_case(vecs[t]);
            if (t == 0) check_caps_a();
            if (t == 2) begin
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("z_peak[%0d]", g), cap[g][31], 2080800);
                    check($sformatf("z_first[%0d]", g), cap[g][0], 65025);
                    check($sformatf("z_last[%0d]", g), cap[g][62], 65025);
                end
            end
        end

        // Abort a long run in ISSUE with an asynchronous reset, then rerun cleanly
        v = vecs[2];
        prep(v);
        launch(v);
        while (cyc < 38) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int g = 0; g < 2; g++) check($sformatf("abort_in_issue[%0d]", g), rd_w[g], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("reset_async[%0d]", g), any_w[g], 0);
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("reset_hold[%0d]", g), any_w[g], 0);
        #2 rst_n = 1'b1;
        v = vecs[0];
        v.p1 = 0;
        v.p2 = 0;
        run_case(v);
        check_caps_a();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

`default_nettype wire
